out_port_tx: RTL
================

Name: out_port_tx

Overview:
- Consumer end of the register file's output register (R15 / cpu_out).
- Snoops the register-file write port and captures every byte the CPU writes to the output address into a small FIFO.
- Serialises each captured byte onto a single-wire UART-style line (8N1, LSB first), so CPU output leaves the chip without stalling the core.
- Sits beside the register file and is driven by the same write_enable / WA / ALUResult signals.

Parameters:
- DATA_W, 8, width of captured data (matches ALUResult).
- ADDR_W, 4, width of the write-address bus.
- OUT_ADDR, 15, register address whose writes are captured.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- CLKS_PER_BIT, 4, clock cycles per serial bit (≥1).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- write_enable  input  1  register-file write strobe (snooped).
- WA  input  ADDR_W  register-file write address (snooped).
- ALUResult  input  DATA_W  register-file write data (snooped).
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line (state ≠ IDLE).
- fifo_count  output  $clog2(DEPTH)+1  number of bytes queued, excluding the byte in transmission.
- overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (RST_N low, asynchronous, immediate):
  - tx=1, busy=0, fifo_count=0, overflow=0.
  - FSM=IDLE; FIFO pointers cleared. Contents are don't-care.
  - Reset mid-frame aborts the frame: tx goes high at once and queued bytes are lost.
- Capture:
  - Capture fires on a rising edge where write_enable=1 and WA==OUT_ADDR; ALUResult is pushed to the FIFO.
  - Writes to any other address, or with write_enable=0, are ignored.
- Push when full:
  - If fifo_count==DEPTH and no pop occurs in the same cycle, the byte is dropped and overflow is set to 1.
  - overflow clears only on reset.
- Simultaneous push and pop: both take effect, and fifo_count is unchanged. This applies when full: the push is accepted and overflow is not set.
- FSM states are IDLE, START, DATA, STOP. A 0..CLKS_PER_BIT-1 bit timer and a 0..DATA_W-1 bit index are used.
  - IDLE: tx=1. If fifo_count>0 at a rising edge: pop the head into the shift register, go to START, and clear the timer.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After bit DATA_W-1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: IDLE spends exactly one cycle with tx=1 between frames if the FIFO is non-empty. Inter-frame gap = CLKS_PER_BIT stop cycles + 1 idle cycle.
- Latency: capture at edge k → fifo_count=1 after edge k → pop at edge k+1 → tx=0 and busy=1 after edge k+1.
- Frame length: (DATA_W+2)·CLKS_PER_BIT cycles of busy=1 (40 cycles at defaults).
- Timing paths: tx, busy and overflow are registered outputs. fifo_count comes straight from pointer registers, with no combinational path from the inputs.
- Wrap-around: FIFO pointers wrap modulo DEPTH. Ordering is strictly first-in-first-out.

Test Plan:
1. Reset, then one capture of 0xA5 (WA=15, write_enable=1, one cycle) → after one cycle tx low for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then tx high for 4 cycles. busy high for exactly 40 cycles; overflow=0.
2. Write 0x3C with WA=14, write_enable=1; then WA=15 with write_enable=0 → tx stays 1, busy=0, fifo_count=0 for 50 cycles.
3. Captures of 0x01..0x06 on six consecutive edges (defaults):
   - 0x01 is popped at the 2nd edge; 0x02..0x05 fill the FIFO (fifo_count=4).
   - 0x06 is dropped and overflow=1.
   - The line carries exactly 0x01,0x02,0x03,0x04,0x05 in order, with 1 idle cycle between frames. overflow stays 1 afterwards.
4. Push while full and popping: FIFO full (4) at the final stop cycle of a frame, with a capture of 0x77 on the IDLE-pop edge → fifo_count stays 4, overflow=0, and 0x77 is transmitted last.
5. RST_N pulsed low for 1 ns during the DATA state of frame 0x81 with 2 bytes queued → tx=1, busy=0, fifo_count=0 immediately. No further frames after RST_N returns high.
6. Wrap-around: 10 bytes 0x10..0x19, each written only after the previous frame starts → all 10 transmitted in order, overflow=0.

Source files
------------

// File: rtl/out_port_tx.sv
// Output-port transmitter: snoops register-file writes to OUT_ADDR, queues the
// bytes in a small FIFO and serialises each one as an 8N1 frame, LSB first.
module out_port_tx #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int OUT_ADDR     = 15,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        WA,
  input  logic [DATA_W-1:0]        ALUResult,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [TW-1:0]     timer_q;
  logic [IW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q, busy_q, overflow_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     wr_ptr_q, rd_ptr_q;
  logic              push_req, pop, push;
  logic              timer_done;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign push_req   = write_enable && (WA == ADDR_W'(OUT_ADDR));
  assign pop        = (state_q == IDLE) && (fifo_count != '0);
  assign push       = push_req && ((fifo_count != CW'(DEPTH)) || pop);
  assign timer_done = (timer_q == TW'(CLKS_PER_BIT - 1));

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= ALUResult;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && !push) overflow_q <= 1'b1;
    end
  end

  // tx/busy are registered alongside the state, so each transition loads the
  // value the line must carry in the state being entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q[PW-1:0]];
            timer_q <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (timer_done) begin
            timer_q <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (timer_done) begin
            timer_q <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == IW'(DATA_W - 1)) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STOP: begin
          if (timer_done) begin
            timer_q <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
